mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit; consumes the decoder's memory controls (mem read/write, load extmode, store extmode).
//  Drives a variable-latency data-memory req/ack port with byte enables; aligns and extends load data.
//  Stalls the pipeline while an access is outstanding; flags misaligned accesses and ack timeouts.
// PARAMETERS
//  MAX_WAIT   16  cycles REQ may wait for mem_ack before abort; 0 = never time out
//  CNT_W      5   width of wait counter; must hold MAX_WAIT
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rstn        in   1   asynchronous active-low reset
//  op_valid    in   1   MEM-stage instruction valid; held stable while stall=1
//  mem_read    in   1   load request
//  mem_write   in   1   store request
//  ld_mode     in   3   000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others = LW
//  st_mode     in   3   000 SW, 010 SB, 100 SH; others = SW
//  addr        in   32  byte address (ALU result)
//  wdata       in   32  store data (rs2)
//  stall       out  1   freeze upstream stages (combinational)
//  ld_data     out  32  aligned, extended load result (registered)
//  ld_valid    out  1   1-cycle pulse: ld_data valid
//  misalign    out  1   1-cycle pulse: misaligned access dropped
//  bus_err     out  1   1-cycle pulse: access aborted by timeout
//  mem_req     out  1   memory request (registered)
//  mem_we      out  1   1 = write
//  mem_addr    out  32  word address {addr[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-replicated store data
//  mem_ack     in   1   memory completes request this cycle
//  mem_rdata   in   32  read word, valid with mem_ack
// BEHAVIOUR
//  Reset (async): state IDLE; mem_req/mem_we/ld_valid/misalign/bus_err=0; ld_data, mem_addr, mem_be, mem_wdata, wait counter = 0.
//  start = op_valid & (mem_read|mem_write) & state!=REQ; both read and write set -> load, write ignored.
//  States: IDLE, REQ, DONE.
//  IDLE/DONE: on start with aligned addr -> REQ; latch mem_addr/mem_we/mem_be/mem_wdata; mem_req=1 from next cycle.
//   Misaligned start -> misalign=1 next cycle, no request, stays/returns IDLE; else DONE->IDLE.
//  REQ: mem_req held with stable addr/be/wdata/we until mem_ack sampled high -> DONE, mem_req=0 same edge.
//   Load: ld_data latched from mem_rdata on that edge; ld_valid=1 during DONE.
//   Counter clears on REQ entry, increments each REQ cycle without ack.
//   Count reaches MAX_WAIT (MAX_WAIT>0) -> mem_req=0, bus_err=1 for one cycle, -> IDLE.
//  stall = (start & aligned) | state==REQ; misaligned start never stalls.
//  Minimum latency: issue T, mem_req T+1, ack T+1 -> ld_valid T+2; stall high T and T+1.
//  Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops always aligned.
//  Store: SB be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH be=addr[1]?1100:0011, {2{wdata[15:0]}}; SW be=1111.
//  Load: byte lane mem_rdata[8*addr[1:0]+:8], half lane mem_rdata[16*addr[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend.
//   Loads drive be=1111.
//  mem_ack outside REQ is ignored. Reset mid-REQ drops mem_req immediately; no pulses issued.
// TESTING
//  LW addr=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> mem_req 3 cycles, ld_data=0xDEADBEEF, ld_valid 1 cycle
//  LB addr=0x103, rdata=0x80112233 -> mem_addr=0x100, ld_data=0xFFFFFF80; LBU same -> 0x00000080
//  SH addr=0x22, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, no ld_valid
//  LW addr=0x101 -> misalign pulse, mem_req stays 0, stall stays 0
//  LW, mem_ack never high, MAX_WAIT=16 -> after 16 REQ cycles mem_req=0, bus_err pulse, stall released
//  rstn low while in REQ -> mem_req=0 asynchronously; after release, next LW completes normally

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with a req/ack data-memory port.
// Aligns/extends loads, replicates stores, flags misalign and timeouts.
module mem_access_unit #(
   parameter int unsigned MAX_WAIT = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        op_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  ld_mode,
   input  logic [2:0]  st_mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   state_e state_q, state_d;
   logic mem_req_q, mem_req_d;
   logic mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0] mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic ld_valid_q, ld_valid_d;
   logic misalign_q, misalign_d;
   logic bus_err_q, bus_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0] lmode_q, lmode_d;
   logic [1:0] off_q, off_d;

   logic start, aligned, half_op, byte_op;
   logic [3:0] st_be;
   logic [31:0] st_data;
   logic [7:0] rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ld_ext;
   logic [CNT_W-1:0] cnt_inc;

   // Request decode: alignment, store lanes, stall.
   always_comb begin
      start   = op_valid & (mem_read | mem_write) & (state_q != REQ);
      half_op = mem_read ? (ld_mode == 3'b011 || ld_mode == 3'b100)
                         : (st_mode == 3'b100);
      byte_op = mem_read ? (ld_mode == 3'b001 || ld_mode == 3'b010)
                         : (st_mode == 3'b010);
      if (byte_op)
         aligned = 1'b1;
      else if (half_op)
         aligned = ~addr[0];
      else
         aligned = (addr[1:0] == 2'b00);
      st_be   = 4'b1111;
      st_data = wdata;
      if (!mem_read && byte_op) begin
         st_be   = 4'b0001 << addr[1:0];
         st_data = {4{wdata[7:0]}};
      end else if (!mem_read && half_op) begin
         st_be   = addr[1] ? 4'b1100 : 4'b0011;
         st_data = {2{wdata[15:0]}};
      end
      stall = (start & aligned) | (state_q == REQ);
   end

   // Load lane select and sign/zero extension.
   always_comb begin
      rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
      rd_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (lmode_q)
         3'b001:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b010:  ld_ext = {24'h0, rd_byte};
         3'b011:  ld_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  ld_ext = {16'h0, rd_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Next-state logic for the access FSM and its registered outputs.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      ld_data_d   = ld_data_q;
      ld_valid_d  = 1'b0;
      misalign_d  = 1'b0;
      bus_err_d   = 1'b0;
      cnt_d       = cnt_q;
      lmode_d     = lmode_q;
      off_d       = off_q;
      cnt_inc     = cnt_q + 1'b1;
      case (state_q)
         REQ: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  ld_data_d  = ld_ext;
                  ld_valid_d = 1'b1;
               end
            end else if (MAX_WAIT != 0 && cnt_inc == MAX_CNT) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            if (start && aligned) begin
               state_d     = REQ;
               mem_req_d   = 1'b1;
               mem_we_d    = ~mem_read;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_be_d    = mem_read ? 4'b1111 : st_be;
               mem_wdata_d = st_data;
               cnt_d       = '0;
               lmode_d     = ld_mode;
               off_d       = addr[1:0];
            end else if (start) begin
               misalign_d = 1'b1;
            end
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         ld_data_q   <= '0;
         ld_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         cnt_q       <= '0;
         lmode_q     <= '0;
         off_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         ld_data_q   <= ld_data_d;
         ld_valid_q  <= ld_valid_d;
         misalign_q  <= misalign_d;
         bus_err_q   <= bus_err_d;
         cnt_q       <= cnt_d;
         lmode_q     <= lmode_d;
         off_q       <= off_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;
   assign ld_data   = ld_data_q;
   assign ld_valid  = ld_valid_q;
   assign misalign  = misalign_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed ops, a req/ack memory model,
// and a queue-based scoreboard checked by an independent monitor.
module tb_mem_access_unit;

   localparam int K_REQ = 0;
   localparam int K_LD  = 1;
   localparam int K_MIS = 2;
   localparam int K_ERR = 3;

   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      int          ncyc;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic op_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0] ld_mode = 3'b000, st_mode = 3'b000;
   logic [31:0] addr = '0, wdata = '0;
   logic stall, ld_valid, misalign, bus_err, mem_req, mem_we;
   logic [31:0] ld_data, mem_addr, mem_wdata;
   logic [3:0] mem_be;
   logic mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int tests = 0;
   int fails = 0;
   int mem_dly = 1;
   logic [31:0] mem_rd_val = '0;
   int mem_cyc = 0;
   int reqc = 0;
   exp_t sb[$];

   mem_access_unit #(.MAX_WAIT(16), .CNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .op_valid(op_valid),
      .mem_read(mem_read), .mem_write(mem_write),
      .ld_mode(ld_mode), .st_mode(st_mode),
      .addr(addr), .wdata(wdata), .stall(stall),
      .ld_data(ld_data), .ld_valid(ld_valid),
      .misalign(misalign), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic exp_req(input logic we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d,
                          input int n);
      exp_t e;
      e.kind = K_REQ; e.we = we; e.addr = a;
      e.be = be; e.data = d; e.ncyc = n;
      sb.push_back(e);
   endtask

   task automatic exp_ev(input int k, input logic [31:0] d,
                         input int n);
      exp_t e;
      e.kind = k; e.we = 1'b0; e.addr = '0;
      e.be = '0; e.data = d; e.ncyc = n;
      sb.push_back(e);
   endtask

   task automatic pop(input int k, output exp_t e, output bit ok);
      ok = 1'b0;
      e.kind = -1; e.we = 1'b0; e.addr = '0;
      e.be = '0; e.data = '0; e.ncyc = 0;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind %0d expected none", k);
      end else begin
         e = sb.pop_front();
         if (e.kind != k) begin
            fails++;
            $display("FAIL event_kind: got %0d expected %0d", k, e.kind);
         end else begin
            ok = 1'b1;
         end
      end
   endtask

   // Memory model: ack after mem_dly request cycles (0 = never).
   initial forever begin
      @(negedge clk);
      if (!rstn) begin
         mem_cyc = 0;
         mem_ack = 1'b0;
      end else if (mem_req && !mem_ack) begin
         mem_cyc++;
         if (mem_cyc == mem_dly) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_rd_val;
         end
      end else begin
         mem_ack = 1'b0;
         mem_cyc = 0;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial forever begin
      exp_t e;
      bit ok;
      @(negedge clk);
      #1;
      if (!rstn) begin
         reqc = 0;
      end else begin
         if (mem_req) reqc++;
         if (mem_req && mem_ack) begin
            pop(K_REQ, e, ok);
            if (ok) begin
               chk("req_we", 32'(mem_we), 32'(e.we));
               chk("req_addr", mem_addr, e.addr);
               chk("req_be", 32'(mem_be), 32'(e.be));
               if (e.we) chk("req_wdata", mem_wdata, e.data);
               chk("req_cycles", reqc, e.ncyc);
            end
            reqc = 0;
         end
         if (ld_valid) begin
            pop(K_LD, e, ok);
            if (ok) chk("ld_data", ld_data, e.data);
         end
         if (misalign) pop(K_MIS, e, ok);
         if (bus_err) begin
            pop(K_ERR, e, ok);
            if (ok) chk("timeout_cycles", reqc, e.ncyc);
            reqc = 0;
         end
      end
   end

   // Issue one op, hold it while the request is outstanding.
   task automatic do_op(input string nm, input logic rd,
                        input logic wr, input logic [2:0] lm,
                        input logic [2:0] sm, input logic [31:0] a,
                        input logic [31:0] wd, input int d,
                        input logic [31:0] rdat, input logic es);
      int n;
      mem_dly    = d;
      mem_rd_val = rdat;
      @(negedge clk);
      op_valid  = 1'b1;
      mem_read  = rd;
      mem_write = wr;
      ld_mode   = lm;
      st_mode   = sm;
      addr      = a;
      wdata     = wd;
      #1;
      chk({nm, "_stall_issue"}, 32'(stall), 32'(es));
      @(posedge clk);
      #1;
      n = 0;
      while (mem_req && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         tests++;
         fails++;
         $display("FAIL %s_wait: got timeout expected mem_req drop", nm);
      end
      op_valid  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      chk({nm, "_stall_release"}, 32'(stall), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #12;
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_ld_valid", 32'(ld_valid), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      exp_req(1'b0, 32'h100, 4'hF, 32'h0, 3);
      exp_ev(K_LD, 32'hDEADBEEF, 0);
      do_op("lw", 1, 0, 3'b000, 3'b000, 32'h100, 0, 3, 32'hDEADBEEF, 1);

      exp_req(1'b0, 32'h100, 4'hF, 32'h0, 1);
      exp_ev(K_LD, 32'hFFFFFF80, 0);
      do_op("lb", 1, 0, 3'b001, 3'b000, 32'h103, 0, 1, 32'h80112233, 1);

      exp_req(1'b0, 32'h100, 4'hF, 32'h0, 1);
      exp_ev(K_LD, 32'h00000080, 0);
      do_op("lbu", 1, 0, 3'b010, 3'b000, 32'h103, 0, 1, 32'h80112233, 1);

      exp_req(1'b1, 32'h20, 4'b1100, 32'hABCDABCD, 2);
      do_op("sh_hi", 0, 1, 3'b000, 3'b100, 32'h22, 32'h0000ABCD, 2, 0, 1);

      exp_req(1'b1, 32'h20, 4'b0011, 32'h56785678, 1);
      do_op("sh_lo", 0, 1, 3'b000, 3'b100, 32'h20, 32'h12345678, 1, 0, 1);

      exp_req(1'b1, 32'h40, 4'b0010, 32'h5A5A5A5A, 1);
      do_op("sb1", 0, 1, 3'b000, 3'b010, 32'h41, 32'hFFFFFF5A, 1, 0, 1);

      exp_req(1'b1, 32'h40, 4'b1000, 32'hC3C3C3C3, 2);
      do_op("sb3", 0, 1, 3'b000, 3'b010, 32'h43, 32'h000000C3, 2, 0, 1);

      exp_req(1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 1);
      do_op("sw", 0, 1, 3'b000, 3'b000, 32'h80, 32'hCAFEF00D, 1, 0, 1);

      exp_req(1'b0, 32'h100, 4'hF, 32'h0, 1);
      exp_ev(K_LD, 32'hFFFF8011, 0);
      do_op("lh", 1, 0, 3'b011, 3'b000, 32'h102, 0, 1, 32'h80112233, 1);

      exp_req(1'b0, 32'h100, 4'hF, 32'h0, 2);
      exp_ev(K_LD, 32'h0000F00D, 0);
      do_op("lhu", 1, 0, 3'b100, 3'b000, 32'h100, 0, 2, 32'h1234F00D, 1);

      exp_req(1'b0, 32'h300, 4'hF, 32'h0, 1);
      exp_ev(K_LD, 32'h0BADF00D, 0);
      do_op("rd_wr", 1, 1, 3'b000, 3'b010, 32'h300, 32'h77, 1,
            32'h0BADF00D, 1);

      exp_ev(K_MIS, 0, 0);
      do_op("lw_mis", 1, 0, 3'b000, 3'b000, 32'h101, 0, 1, 0, 0);

      exp_ev(K_MIS, 0, 0);
      do_op("sh_mis", 0, 1, 3'b000, 3'b100, 32'h23, 32'h1, 1, 0, 0);

      exp_ev(K_ERR, 0, 16);
      do_op("lw_tmo", 1, 0, 3'b000, 3'b000, 32'h400, 0, 0, 0, 1);

      mem_dly = 0;
      @(negedge clk);
      op_valid = 1'b1;
      mem_read = 1'b1;
      ld_mode  = 3'b000;
      addr     = 32'h500;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mid_req_before", 32'(mem_req), 32'd1);
      #2;
      rstn = 1'b0;
      op_valid = 1'b0;
      mem_read = 1'b0;
      #1;
      chk("rst_mid_req_drop", 32'(mem_req), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      exp_req(1'b0, 32'h200, 4'hF, 32'h0, 1);
      exp_ev(K_LD, 32'h12345678, 0);
      do_op("lw_post", 1, 0, 3'b000, 3'b000, 32'h200, 0, 1,
            32'h12345678, 1);

      repeat (5) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
